// File: rtl/nand_op_sequencer_if.sv
// Bundles the op request, write/read data streams, completion report and nand_master command port.
// master: requester and nand_master side; slave: the sequencer.
interface nand_op_sequencer_if;
   logic        op_valid;
   logic        op_ready;
   logic [1:0]  op_code;
   logic [15:0] op_col;
   logic [23:0] op_row;
   logic [7:0]  wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        done;
   logic [7:0]  status;
   logic        fail;
   logic        err_timeout;
   logic [7:0]  m_cmd_in;
   logic [7:0]  m_data_in;
   logic        m_activate;
   logic [7:0]  m_data_out;
   logic        m_busy;

   modport master (
      output op_valid, op_code, op_col, op_row, wr_data, wr_valid, rd_ready,
             m_data_out, m_busy,
      input  op_ready, wr_ready, rd_data, rd_valid, done, status, fail, err_timeout,
             m_cmd_in, m_data_in, m_activate
   );

   modport slave (
      input  op_valid, op_code, op_col, op_row, wr_data, wr_valid, rd_ready,
             m_data_out, m_busy,
      output op_ready, wr_ready, rd_data, rd_valid, done, status, fail, err_timeout,
             m_cmd_in, m_data_in, m_activate
   );
endinterface

// File: rtl/nand_op_sequencer.sv
// Turns page read / page program / block erase requests into nand_master primitive commands.
// Optional busy-wait timeout: define NAND_SEQ_TIMEOUT_EN (adds TIMEOUT_CYCLES and a sticky err_timeout).
module nand_op_sequencer #(
   parameter int unsigned PAGE_BYTES      = 2048,
   parameter int unsigned ISSUE_GAP       = 2,
   parameter logic [7:0]  CMD_SET_ADDR    = 8'h0D,
   parameter logic [7:0]  CMD_READ_PAGE   = 8'h04,
   parameter logic [7:0]  CMD_PROG_PAGE   = 8'h05,
   parameter logic [7:0]  CMD_ERASE       = 8'h06,
   parameter logic [7:0]  CMD_READ_STATUS = 8'h07,
   parameter logic [7:0]  CMD_GET_BYTE    = 8'h08,
   parameter logic [7:0]  CMD_PUT_BYTE    = 8'h09
`ifdef NAND_SEQ_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES  = 1000000
`endif
) (
   input logic                clk,
   input logic                reset,
   nand_op_sequencer_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(PAGE_BYTES + 1);
   localparam int unsigned GAP_W = $clog2(ISSUE_GAP + 2);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAGE_BYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(ISSUE_GAP);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_PROG  = 2'b01;
   localparam logic [1:0] OP_ERASE = 2'b10;
   localparam logic [1:0] OP_ILL   = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_OP, S_RD_BYTE, S_RD_HOLD, S_WR_WAIT, S_WR_BYTE, S_STAT, S_DONE
   } state_t;

   state_t           state;
   logic [1:0]       op_code_q;
   logic [15:0]      col_q;
   logic [23:0]      row_q;
   logic [2:0]       addr_idx;
   logic [CNT_W-1:0] byte_cnt;
   logic             wait_ph;
   logic [GAP_W-1:0] gap_cnt;

   logic       op_ready;
   logic       wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       done;
   logic [7:0] status;
   logic       fail;
   logic [7:0] m_cmd_in;
   logic [7:0] m_data_in;
   logic       m_activate;

   logic       issue_st_c;
   logic       issue_c;
   logic       cmpl_c;
   logic       addr_last_c;
   logic [7:0] cmd_c;
   logic [7:0] data_c;

   // Command/data for the primitive owned by the current state, plus issue/complete strobes.
   always_comb begin
      cmd_c       = CMD_GET_BYTE;
      data_c      = 8'h00;
      issue_st_c  = 1'b1;
      addr_last_c = (op_code_q == OP_ERASE) ? (addr_idx == 3'd2) : (addr_idx == 3'd4);
      case (state)
         S_ADDR: begin
            cmd_c = CMD_SET_ADDR;
            if (op_code_q == OP_ERASE) begin
               case (addr_idx)
                  3'd0:    data_c = row_q[7:0];
                  3'd1:    data_c = row_q[15:8];
                  default: data_c = row_q[23:16];
               endcase
            end else begin
               case (addr_idx)
                  3'd0:    data_c = col_q[7:0];
                  3'd1:    data_c = col_q[15:8];
                  3'd2:    data_c = row_q[7:0];
                  3'd3:    data_c = row_q[15:8];
                  default: data_c = row_q[23:16];
               endcase
            end
         end
         S_OP: begin
            case (op_code_q)
               OP_READ: cmd_c = CMD_READ_PAGE;
               OP_PROG: cmd_c = CMD_PROG_PAGE;
               default: cmd_c = CMD_ERASE;
            endcase
         end
         S_RD_BYTE: cmd_c = CMD_GET_BYTE;
         S_WR_BYTE: begin
            cmd_c  = CMD_PUT_BYTE;
            data_c = m_data_in;
         end
         S_STAT: cmd_c = CMD_READ_STATUS;
         default: issue_st_c = 1'b0;
      endcase
      issue_c = issue_st_c && !wait_ph && !bus.m_busy;
      cmpl_c  = issue_st_c && wait_ph && (gap_cnt == '0) && !bus.m_busy;
   end

`ifdef NAND_SEQ_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt;
   logic            err_timeout;
`endif

   // Operation sequencer: primitive issue/wait handshake plus per-op state walk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         op_code_q  <= 2'b00;
         col_q      <= 16'h0000;
         row_q      <= 24'h000000;
         addr_idx   <= 3'd0;
         byte_cnt   <= '0;
         wait_ph    <= 1'b0;
         gap_cnt    <= '0;
         op_ready   <= 1'b1;
         wr_ready   <= 1'b0;
         rd_data    <= 8'h00;
         rd_valid   <= 1'b0;
         done       <= 1'b0;
         status     <= 8'h00;
         fail       <= 1'b0;
         m_cmd_in   <= 8'h00;
         m_data_in  <= 8'h00;
         m_activate <= 1'b0;
`ifdef NAND_SEQ_TIMEOUT_EN
         to_cnt      <= '0;
         err_timeout <= 1'b0;
`endif
      end else begin
         m_activate <= 1'b0;
         wr_ready   <= 1'b0;
         done       <= 1'b0;

         if (issue_c) begin
            m_cmd_in   <= cmd_c;
            m_data_in  <= data_c;
            m_activate <= 1'b1;
            wait_ph    <= 1'b1;
            gap_cnt    <= GAP_LOAD;
         end else if (wait_ph && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
         if (cmpl_c) begin
            wait_ph <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (bus.op_valid) begin
                  op_code_q <= bus.op_code;
                  col_q     <= bus.op_col;
                  row_q     <= bus.op_row;
                  addr_idx  <= 3'd0;
                  byte_cnt  <= '0;
                  op_ready  <= 1'b0;
                  fail      <= 1'b0;
                  if (bus.op_code == OP_ILL) begin
                     fail  <= 1'b1;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (cmpl_c) begin
                  if (addr_last_c) begin
                     state <= (op_code_q == OP_PROG) ? S_WR_WAIT : S_OP;
                  end else begin
                     addr_idx <= addr_idx + 3'd1;
                  end
               end
            end
            S_OP: begin
               if (cmpl_c) begin
                  state <= (op_code_q == OP_READ) ? S_RD_BYTE : S_STAT;
               end
            end
            S_RD_BYTE: begin
               if (cmpl_c) begin
                  rd_data  <= bus.m_data_out;
                  rd_valid <= 1'b1;
                  state    <= S_RD_HOLD;
               end
            end
            S_RD_HOLD: begin
               if (bus.rd_ready) begin
                  rd_valid <= 1'b0;
                  if (byte_cnt == LAST_BYTE) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                     state    <= S_RD_BYTE;
                  end
               end
            end
            S_WR_WAIT: begin
               if (bus.wr_valid) begin
                  wr_ready  <= 1'b1;
                  m_data_in <= bus.wr_data;
                  state     <= S_WR_BYTE;
               end
            end
            S_WR_BYTE: begin
               if (cmpl_c) begin
                  if (byte_cnt == LAST_BYTE) begin
                     state <= S_OP;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                     state    <= S_WR_WAIT;
                  end
               end
            end
            S_STAT: begin
               if (cmpl_c) begin
                  status <= bus.m_data_out;
                  fail   <= bus.m_data_out[0];
                  done   <= 1'b1;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               op_ready <= 1'b1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

`ifdef NAND_SEQ_TIMEOUT_EN
         // Abort the op when a primitive stalls or stays busy too long.
         if (issue_c || cmpl_c || !issue_st_c) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_LAST) begin
            to_cnt      <= '0;
            err_timeout <= 1'b1;
            fail        <= 1'b1;
            done        <= 1'b1;
            wait_ph     <= 1'b0;
            state       <= S_DONE;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
`endif
      end
   end

   assign bus.op_ready   = op_ready;
   assign bus.wr_ready   = wr_ready;
   assign bus.rd_data    = rd_data;
   assign bus.rd_valid   = rd_valid;
   assign bus.done       = done;
   assign bus.status     = status;
   assign bus.fail       = fail;
   assign bus.m_cmd_in   = m_cmd_in;
   assign bus.m_data_in  = m_data_in;
   assign bus.m_activate = m_activate;
`ifdef NAND_SEQ_TIMEOUT_EN
   assign bus.err_timeout = err_timeout;
`else
   assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Randomized bench for nand_op_sequencer against a nand_master model and an op-level expectation builder.
module tb_nand_op_sequencer;
   localparam int unsigned PB = 4;
   localparam logic [7:0] C_SET = 8'h0D, C_RDP = 8'h04, C_PRG = 8'h05, C_ERS = 8'h06;
   localparam logic [7:0] C_STS = 8'h07, C_GET = 8'h08, C_PUT = 8'h09;

   logic clk = 1'b0;
   logic reset;
   nand_op_sequencer_if bif ();

   nand_op_sequencer #(
      .PAGE_BYTES(PB),
      .ISSUE_GAP(2)
`ifdef NAND_SEQ_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(50)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bif)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Shared stimulus / model state (each variable has a single writing process)
   logic [7:0]  page_mem [PB];
   logic [7:0]  prog_mem [PB];
   logic [7:0]  nand_stat;
   int          lat_fixed;
   bit          stuck;
   bit          stall_mode;
   bit          wr_en;
   int          rd_base;
   int          wr_base;
   int          wr_cnt;
   logic [15:0] log_q [$];
   logic [7:0]  rd_got [$];
   logic [15:0] exp_q [$];
   logic [7:0]  exp_status;

   // nand_master model: logs each primitive, goes busy, serves page bytes and status.
   initial begin
      int bcnt;
      int get_idx;
      int lat;
      bif.m_busy     = 1'b0;
      bif.m_data_out = 8'h00;
      bcnt           = 0;
      get_idx        = 0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            bcnt = 0;
            bif.m_busy <= 1'b0;
         end else begin
            if (bif.m_activate) begin
               lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(12, 1));
               log_q.push_back({bif.m_cmd_in, bif.m_data_in});
               if (bif.m_cmd_in == C_RDP) get_idx = 0;
               if (bif.m_cmd_in == C_GET) begin
                  bif.m_data_out <= page_mem[get_idx % PB];
                  get_idx++;
               end
               if (bif.m_cmd_in == C_STS) bif.m_data_out <= nand_stat;
               if (stuck && bif.m_cmd_in == C_ERS) lat = 1 << 30;
               bcnt = lat;
            end else if (bcnt > 0) begin
               bcnt--;
            end
            bif.m_busy <= (bcnt > 0);
         end
      end
   end

   // Read consumer: random rd_ready, or a 3-cycle stall on byte 2 in directed mode.
   initial begin
      int stall_n;
      int k;
      bif.rd_ready = 1'b0;
      stall_n = 0;
      forever begin
         @(negedge clk);
         k = rd_got.size() - rd_base;
         if (k == 0) stall_n = 0;
         if (stall_mode && bif.rd_valid && k == 1 && stall_n < 3) begin
            bif.rd_ready = 1'b0;
            stall_n++;
            chk("rd_hold_data", 32'(bif.rd_data), 32'h0000_00BB);
         end else begin
            bif.rd_ready = stall_mode ? 1'b1 : ($urandom_range(2, 0) != 0);
            if (bif.rd_valid && bif.rd_ready) rd_got.push_back(bif.rd_data);
         end
      end
   end

   // Program data source with random wr_valid gaps.
   initial begin
      bif.wr_valid = 1'b0;
      bif.wr_data  = 8'h00;
      wr_cnt       = 0;
      forever begin
         @(negedge clk);
         if (bif.wr_ready) begin
            wr_cnt++;
            bif.wr_valid = 1'b0;
         end
         if (wr_en && !bif.wr_valid && (wr_cnt - wr_base) < PB && $urandom_range(1, 0) == 1) begin
            bif.wr_valid = 1'b1;
            bif.wr_data  = prog_mem[wr_cnt - wr_base];
         end
      end
   end

   // Expected primitive sequence for one op.
   task automatic build_exp(input logic [1:0] code, input logic [15:0] col, input logic [23:0] row);
      exp_q.delete();
      if (code == 2'b11) return;
      if (code != 2'b10) begin
         exp_q.push_back({C_SET, col[7:0]});
         exp_q.push_back({C_SET, col[15:8]});
      end
      exp_q.push_back({C_SET, row[7:0]});
      exp_q.push_back({C_SET, row[15:8]});
      exp_q.push_back({C_SET, row[23:16]});
      if (code == 2'b00) begin
         exp_q.push_back({C_RDP, 8'h00});
         for (int i = 0; i < PB; i++) exp_q.push_back({C_GET, 8'h00});
      end else if (code == 2'b01) begin
         for (int i = 0; i < PB; i++) exp_q.push_back({C_PUT, prog_mem[i]});
         exp_q.push_back({C_PRG, 8'h00});
         exp_q.push_back({C_STS, 8'h00});
      end else begin
         exp_q.push_back({C_ERS, 8'h00});
         exp_q.push_back({C_STS, 8'h00});
      end
   endtask

   task automatic start_op(input logic [1:0] code, input logic [15:0] col, input logic [23:0] row);
      rd_base = rd_got.size();
      wr_base = wr_cnt;
      @(negedge clk);
      chk("op_ready_idle", 32'(bif.op_ready), 32'd1);
      bif.op_valid = 1'b1;
      bif.op_code  = code;
      bif.op_col   = col;
      bif.op_row   = row;
      wr_en        = (code == 2'b01);
      @(negedge clk);
      bif.op_valid = 1'b0;
      chk("op_ready_busy", 32'(bif.op_ready), 32'd0);
   endtask

   task automatic run_op(input logic [1:0] code, input logic [15:0] col, input logic [23:0] row,
                         output int cyc);
      int base;
      int n;
      logic exp_fail;
      base = log_q.size();
      build_exp(code, col, row);
      start_op(code, col, row);
      cyc = 1;
      while (bif.done !== 1'b1 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", 32'(bif.done), 32'd1);
      if (code == 2'b01 || code == 2'b10) exp_status = nand_stat;
      exp_fail = (code == 2'b11) ? 1'b1 : (code == 2'b00) ? 1'b0 : nand_stat[0];
      chk("fail", 32'(bif.fail), 32'(exp_fail));
      chk("status", 32'(bif.status), 32'(exp_status));
      n = log_q.size() - base;
      chk("cmd_count", 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < n && i < exp_q.size(); i++)
         chk("cmd", 32'(log_q[base + i]), 32'(exp_q[i]));
      if (code == 2'b00) begin
         chk("rd_count", 32'(rd_got.size() - rd_base), 32'(PB));
         for (int i = 0; i < PB && rd_base + i < rd_got.size(); i++)
            chk("rd_byte", 32'(rd_got[rd_base + i]), 32'(page_mem[i]));
      end
      if (code == 2'b01) chk("wr_count", 32'(wr_cnt - wr_base), 32'(PB));
      @(negedge clk);
      wr_en = 1'b0;
      chk("done_pulse", 32'(bif.done), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_op_ready"}, 32'(bif.op_ready), 32'd1);
      chk({tag, "_done"}, 32'(bif.done), 32'd0);
      chk({tag, "_rd_valid"}, 32'(bif.rd_valid), 32'd0);
      chk({tag, "_rd_data"}, 32'(bif.rd_data), 32'd0);
      chk({tag, "_wr_ready"}, 32'(bif.wr_ready), 32'd0);
      chk({tag, "_status"}, 32'(bif.status), 32'd0);
      chk({tag, "_fail"}, 32'(bif.fail), 32'd0);
      chk({tag, "_m_activate"}, 32'(bif.m_activate), 32'd0);
      chk({tag, "_m_cmd_in"}, 32'(bif.m_cmd_in), 32'd0);
      chk({tag, "_m_data_in"}, 32'(bif.m_data_in), 32'd0);
      chk({tag, "_err_timeout"}, 32'(bif.err_timeout), 32'd0);
   endtask

   initial begin
      int cyc;
      int w;
      reset        = 1'b1;
      bif.op_valid = 1'b0;
      bif.op_code  = 2'b00;
      bif.op_col   = 16'h0000;
      bif.op_row   = 24'h000000;
      lat_fixed    = 10;
      stuck        = 1'b0;
      stall_mode   = 1'b0;
      wr_en        = 1'b0;
      rd_base      = 0;
      wr_base      = 0;
      exp_status   = 8'h00;
      nand_stat    = 8'h00;
      for (int i = 0; i < PB; i++) begin
         page_mem[i] = 8'h00;
         prog_mem[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      reset = 1'b0;

      // Erase of row 012345, status E0
      nand_stat = 8'hE0;
      run_op(2'b10, 16'h0000, 24'h012345, cyc);

      // Read with a rd_ready stall on byte 2
      page_mem[0] = 8'hAA; page_mem[1] = 8'hBB; page_mem[2] = 8'hCC; page_mem[3] = 8'hDD;
      stall_mode = 1'b1;
      run_op(2'b00, 16'h0000, 24'h000001, cyc);
      stall_mode = 1'b0;

      // Program 11..44, status 01 reports fail
      prog_mem[0] = 8'h11; prog_mem[1] = 8'h22; prog_mem[2] = 8'h33; prog_mem[3] = 8'h44;
      nand_stat = 8'h01;
      run_op(2'b01, 16'h0123, 24'h00ABCD, cyc);

      // Illegal op code
      run_op(2'b11, 16'h0000, 24'h000000, cyc);
      chk("illegal_latency_le2", 32'(cyc <= 2), 32'd1);

      // Reset in the middle of a read after two bytes
      for (int i = 0; i < PB; i++) page_mem[i] = 8'($urandom);
      start_op(2'b00, 16'h0040, 24'h000777);
      w = 0;
      while ((rd_got.size() - rd_base) < 2 && w < 5000) begin
         @(negedge clk);
         w++;
      end
      chk("midread_two_bytes", 32'(w < 5000), 32'd1);
      #2 reset = 1'b1;
      #1 check_reset_values("midrst");
      @(negedge clk);
      reset      = 1'b0;
      exp_status = 8'h00;
      nand_stat  = 8'h5A;
      run_op(2'b10, 16'h0000, 24'hFEDCBA, cyc);

      // Randomized ops with random busy latency and handshake gaps
      lat_fixed = 0;
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < PB; i++) begin
            page_mem[i] = 8'($urandom);
            prog_mem[i] = 8'($urandom);
         end
         nand_stat = 8'($urandom);
         run_op(2'($urandom_range(3, 0)), 16'($urandom), 24'($urandom), cyc);
      end

`ifdef NAND_SEQ_TIMEOUT_EN
      // Busy stuck after ERASE: timeout aborts the op
      stuck = 1'b1;
      lat_fixed = 10;
      start_op(2'b10, 16'h0000, 24'h000010);
      w = 0;
      while (bif.done !== 1'b1 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      chk("to_done", 32'(bif.done), 32'd1);
      chk("to_err", 32'(bif.err_timeout), 32'd1);
      chk("to_fail", 32'(bif.fail), 32'd1);
      chk("to_status", 32'(bif.status), 32'(exp_status));
      stuck = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("to_cleared", 32'(bif.err_timeout), 32'd0);
`else
      chk("err_timeout_tied", 32'(bif.err_timeout), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nand_op_sequencer.md
Name: nand_op_sequencer

Overview:
- Sequences the nand_master command port (cmd_in / data_in / activate / busy / data_out) so software-facing logic can issue whole-page operations instead of single primitive commands.
- Supported operations: page read, page program and block erase.
- Per operation: loads the address bytes, issues the operation, streams page data through ready/valid ports, then fetches the NAND status byte.
- Sits between the bus-facing register block and nand_master.

Parameters:
- PAGE_BYTES, 2048: data bytes transferred per read/program.
- ISSUE_GAP, 2: cycles after an activate pulse during which m_busy is ignored.
- CMD_SET_ADDR, 8'h0D: nand_master code that shifts m_data_in into the address register.
- CMD_READ_PAGE, 8'h04: nand_master page-read code.
- CMD_PROG_PAGE, 8'h05: nand_master page-program code.
- CMD_ERASE, 8'h06: nand_master block-erase code.
- CMD_READ_STATUS, 8'h07: nand_master read-status code; the status byte appears on m_data_out.
- CMD_GET_BYTE, 8'h08: nand_master code that reads the next page-buffer byte to m_data_out.
- CMD_PUT_BYTE, 8'h09: nand_master code that writes m_data_in to the page buffer.
- TIMEOUT_CYCLES, 1000000: busy-wait limit (optional feature only).

Ports:
- clk  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  operation request
- op_ready  out  1  high in IDLE only; op accepted when op_valid & op_ready
- op_code  in  2  00 read, 01 program, 10 erase, 11 illegal
- op_col  in  16  column address
- op_row  in  24  row (page/block) address
- wr_data  in  8  program data byte
- wr_valid  in  1  program data valid
- wr_ready  out  1  one-cycle pulse when wr_data is captured
- rd_data  out  8  read data byte
- rd_valid  out  1  read data valid, held until rd_ready
- rd_ready  in  1  read data consumer ready
- done  out  1  one-cycle pulse at end of every accepted op
- status  out  8  last NAND status byte
- fail  out  1  valid with done
- err_timeout  out  1  sticky busy-timeout flag
- m_cmd_in  out  8  to nand_master cmd_in
- m_data_in  out  8  to nand_master data_in
- m_activate  out  1  one-cycle command strobe
- m_data_out  in  8  from nand_master data_out
- m_busy  in  1  from nand_master busy

Behaviour:
- Reset values:
  - All outputs 0 except op_ready=1.
  - m_cmd_in=0, m_data_in=0.
  - State IDLE; counters cleared.
  - Reset mid-operation aborts immediately; nand_master is not notified.
- Primitive issue (ISSUE, WAIT):
  - m_cmd_in and m_data_in are set the same cycle m_activate=1 and hold until the next issue.
  - Issue only when m_busy=0 (otherwise stall in ISSUE).
  - After the pulse, ignore m_busy for ISSUE_GAP cycles, then wait for m_busy=0.
  - The primitive completes in the first cycle m_busy=0 after the gap.
- States: IDLE, ADDR, OP, RD_BYTE, RD_HOLD, WR_WAIT, WR_BYTE, STAT, DONE.
- IDLE:
  - On accept, latch op_code/op_col/op_row.
  - 11 -> DONE with fail=1; no master command is issued.
- ADDR: issue CMD_SET_ADDR once per address byte.
  - Read/program: 5 bytes in order col[7:0], col[15:8], row[7:0], row[15:8], row[23:16].
  - Erase: 3 row bytes, low first.
- Read:
  - OP issues CMD_READ_PAGE.
  - Then per byte: RD_BYTE issues CMD_GET_BYTE.
  - On completion, latch m_data_out into rd_data and assert rd_valid (RD_HOLD).
  - Drop rd_valid the cycle after rd_valid & rd_ready.
  - Repeat PAGE_BYTES times, then go to DONE. No status fetch; fail=0.
- Program:
  - WR_WAIT waits for wr_valid.
  - On capture, pulse wr_ready and load m_data_in; WR_BYTE issues CMD_PUT_BYTE.
  - After PAGE_BYTES bytes, OP issues CMD_PROG_PAGE, then STAT.
- Erase: OP issues CMD_ERASE, then STAT.
- STAT:
  - Issues CMD_READ_STATUS; latch m_data_out into status on completion.
  - fail=status[0].
- DONE: done=1 for one cycle, fail valid that cycle; return to IDLE.
- Byte counter: $clog2(PAGE_BYTES+1) bits, cleared at accept; the last byte is count==PAGE_BYTES-1.
- op_valid during a busy op is ignored (op_ready=0). wr_valid outside WR_WAIT is not consumed.

Optional Feature:
- Macro: NAND_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in every busy-wait, cleared at each issue.
  - Reaching TIMEOUT_CYCLES sets err_timeout (sticky until reset) and goes to DONE with fail=1, status unchanged.
- Undefined: waits indefinitely; err_timeout is tied 0.

Test Plan:
- Erase, row=24'h012345; model busy 10 cycles per command:
  - SET_ADDR with data 45, 23, 01, then ERASE, then READ_STATUS.
  - Model status 8'hE0 -> done, fail=0, status=E0.
- Read, PAGE_BYTES=4, col=0, row=1; model returns AA, BB, CC, DD; rd_ready low 3 cycles on byte 2:
  - Stream is AA, BB, CC, DD with rd_valid held during the stall.
  - Exactly 4 GET_BYTE commands, then done.
- Program, PAGE_BYTES=4, bytes 11, 22, 33, 44 with wr_valid gaps:
  - Four PUT_BYTE commands with matching m_data_in, then PROG_PAGE, then READ_STATUS.
  - Status 8'h01 -> fail=1.
- op_code=11 -> no m_activate; done within 2 cycles; fail=1.
- Reset asserted mid-read after 2 bytes:
  - Outputs return to reset values asynchronously.
  - A new erase then completes normally.
- With NAND_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=50, m_busy stuck high after ERASE -> err_timeout=1 and done with fail=1 after 50 cycles.
